// File: rtl/mdom_wvb_hdr_packer.sv
// Header FIFO feeding a word serializer: wide header bundles are queued and
// emitted as N_WORDS valid/ready words with first/last markers.
module mdom_wvb_hdr_packer #(
   parameter int unsigned HDR_W     = 104,
   parameter int unsigned WORD_W    = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MSW_FIRST = 1,
   localparam int unsigned N_WORDS  = (HDR_W + WORD_W - 1) / WORD_W,
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [HDR_W-1:0]  hdr_in,
   input  logic              hdr_valid,
   output logic              hdr_rdy,
   output logic [WORD_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_rdy,
   output logic              dout_first,
   output logic              dout_last,
   output logic [CNT_W-1:0]  hdr_cnt
);

   localparam int unsigned PAD_W = N_WORDS * WORD_W;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state, state_nxt;
   logic [PAD_W-1:0]  fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PAD_W-1:0]  shreg;
   logic [IDX_W-1:0]  idx;
   logic              rdy_en;
   logic              push, pop, xfer, at_last;
   logic [WORD_W-1:0] word_sel;

   // rdy_en keeps hdr_rdy low until the first edge after reset release
   assign hdr_rdy = rdy_en && (hdr_cnt < CNT_W'(DEPTH));
   assign push    = hdr_valid && hdr_rdy;
   assign at_last = (idx == LAST_IDX);
   assign xfer    = (state == SEND) && dout_rdy;
   assign pop     = (hdr_cnt != '0) && ((state == IDLE) || (xfer && at_last));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (hdr_cnt != '0) state_nxt = SEND;
         SEND: if (xfer && at_last && (hdr_cnt == '0)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      word_sel = '0;
      for (int unsigned k = 0; k < N_WORDS; k++) begin
         if (idx == IDX_W'(k)) begin
            word_sel = (MSW_FIRST != 0) ? shreg[(N_WORDS-1-k)*WORD_W +: WORD_W]
                                        : shreg[k*WORD_W +: WORD_W];
         end
      end
      dout_valid = (state == SEND);
      dout_first = dout_valid && (idx == '0);
      dout_last  = dout_valid && at_last;
      dout       = dout_valid ? word_sel : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         hdr_cnt <= '0;
         shreg   <= '0;
         idx     <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            shreg  <= fifo_mem[rd_ptr];
            idx    <= '0;
         end else if (xfer) begin
            idx <= idx + IDX_W'(1);
         end
         unique case ({push, pop})
            2'b10:   hdr_cnt <= hdr_cnt + CNT_W'(1);
            2'b01:   hdr_cnt <= hdr_cnt - CNT_W'(1);
            default: hdr_cnt <= hdr_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= PAD_W'(hdr_in);
   end

endmodule

// File: tb/tb_mdom_wvb_hdr_packer.sv
// Scoreboard bench: two packers (MSW-first and LSW-first) share stimulus;
// expected words are queued on acceptance and checked by a separate monitor.
module tb_mdom_wvb_hdr_packer;

   typedef struct packed {
      logic [15:0] m;
      logic [15:0] l;
      logic        f;
      logic        la;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [103:0] hdr_in;
   logic         hdr_valid;
   logic         dout_rdy;
   logic         rnd_mode;

   logic         rdy_m, dv_m, df_m, dl_m;
   logic [15:0]  dout_m;
   logic [2:0]   cnt_m;
   logic         rdy_l, dv_l, df_l, dl_l;
   logic [15:0]  dout_l;
   logic [2:0]   cnt_l;

   exp_t         exp_q[$];
   int           n_chk;
   int           n_fail;

   mdom_wvb_hdr_packer #(.HDR_W(104), .WORD_W(16), .DEPTH(4), .MSW_FIRST(1)) dut (
      .clk(clk), .rst_n(rst_n), .hdr_in(hdr_in), .hdr_valid(hdr_valid),
      .hdr_rdy(rdy_m), .dout(dout_m), .dout_valid(dv_m), .dout_rdy(dout_rdy),
      .dout_first(df_m), .dout_last(dl_m), .hdr_cnt(cnt_m)
   );

   mdom_wvb_hdr_packer #(.HDR_W(104), .WORD_W(16), .DEPTH(4), .MSW_FIRST(0)) dut_lsw (
      .clk(clk), .rst_n(rst_n), .hdr_in(hdr_in), .hdr_valid(hdr_valid),
      .hdr_rdy(rdy_l), .dout(dout_l), .dout_valid(dv_l), .dout_rdy(dout_rdy),
      .dout_first(df_l), .dout_last(dl_l), .hdr_cnt(cnt_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rnd_mode) dout_rdy = 1'($urandom_range(0, 1));
   endtask

   task automatic push_exp(input logic [103:0] h);
      logic [111:0] p;
      exp_t e;
      p = {8'h00, h};
      for (int unsigned k = 0; k < 7; k++) begin
         e.m  = p[(6-k)*16 +: 16];
         e.l  = p[k*16 +: 16];
         e.f  = (k == 0);
         e.la = (k == 6);
         exp_q.push_back(e);
      end
   endtask

   // Called at a negedge; hdr_rdy is stable there and is what the next edge sees.
   task automatic send(input logic [103:0] h, input int budget, output bit acc);
      hdr_in    = h;
      hdr_valid = 1'b1;
      acc       = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (rdy_m) begin
            push_exp(h);
            acc = 1'b1;
            tick();
            break;
         end
         tick();
      end
      hdr_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !dv_m) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("drain_complete", 32'(ok), 32'd1);
   endtask

   logic        stalled;
   logic [15:0] hold_m, hold_l;
   logic        hold_f, hold_la;

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         chk("valid_match", 32'(dv_l), 32'(dv_m));
         if (!dv_m) begin
            chk("first_qualified", 32'(df_m), 32'd0);
            chk("last_qualified", 32'(dl_m), 32'd0);
         end
         if (dv_m && stalled) begin
            chk("hold_dout", 32'(dout_m), 32'(hold_m));
            chk("hold_dout_lsw", 32'(dout_l), 32'(hold_l));
            chk("hold_first", 32'(df_m), 32'(hold_f));
            chk("hold_last", 32'(dl_m), 32'(hold_la));
         end
         if (dv_m && dout_rdy) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(dout_m), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("word_msw", 32'(dout_m), 32'(e.m));
               chk("word_lsw", 32'(dout_l), 32'(e.l));
               chk("first", 32'(df_m), 32'(e.f));
               chk("last", 32'(dl_m), 32'(e.la));
               chk("first_lsw", 32'(df_l), 32'(e.f));
               chk("last_lsw", 32'(dl_l), 32'(e.la));
            end
         end else if (dv_m) begin
            stalled = 1'b1;
            hold_m  = dout_m;
            hold_l  = dout_l;
            hold_f  = df_m;
            hold_la = dl_m;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   localparam logic [103:0] H0 = 104'h06_0005_0004_0003_0002_0001_0000;
   localparam logic [103:0] HA = 104'h0F_0E0D_0C0B_0A09_0807_0605_0403;
   localparam logic [103:0] HB = 104'hF1_F2F3_F4F5_F6F7_F8F9_FAFB_FCFD;
   localparam logic [103:0] HC = 104'h5A_1234_5678_9ABC_DEF0_0F1E_2D3C;

   initial begin
      logic [103:0] tbl [6];
      logic [103:0] h;
      bit           acc;
      int           cyc, fpos;

      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; hdr_valid = 1'b0; hdr_in = '0; dout_rdy = 1'b0; rnd_mode = 1'b0;
      stalled = 1'b0;
      tbl[0] = 104'h11_1111_1111_1111_1111_1111_1110;
      tbl[1] = 104'h22_2222_2222_2222_2222_2222_2220;
      tbl[2] = 104'h33_3333_3333_3333_3333_3333_3330;
      tbl[3] = 104'h44_4444_4444_4444_4444_4444_4440;
      tbl[4] = 104'h55_5555_5555_5555_5555_5555_5550;
      tbl[5] = 104'h66_6666_6666_6666_6666_6666_6660;

      // Reset values
      tick(); tick();
      chk("rst_hdr_rdy", 32'(rdy_m), 32'd0);
      chk("rst_dout_valid", 32'(dv_m), 32'd0);
      chk("rst_dout_first", 32'(df_m), 32'd0);
      chk("rst_dout_last", 32'(dl_m), 32'd0);
      chk("rst_dout", 32'(dout_m), 32'd0);
      chk("rst_hdr_cnt", 32'(cnt_m), 32'd0);
      rst_n = 1'b1;
      chk("rdy_before_first_edge", 32'(rdy_m), 32'd0);
      tick();
      chk("rdy_after_first_edge", 32'(rdy_m), 32'd1);

      // Single header, latency and word order
      dout_rdy = 1'b1;
      send(H0, 4, acc);
      chk("single_accept", 32'(acc), 32'd1);
      chk("latency_not_yet_valid", 32'(dv_m), 32'd0);
      tick();
      chk("latency_valid", 32'(dv_m), 32'd1);
      chk("single_word0_msw", 32'(dout_m), 32'h0006);
      chk("single_first_msw", 32'(df_m), 32'd1);
      chk("single_word0_lsw", 32'(dout_l), 32'h0000);
      chk("single_first_lsw", 32'(df_l), 32'd1);
      wait_drain(40);

      // Two back-to-back headers, no bubble
      send(HA, 4, acc);
      chk("b2b_accept_a", 32'(acc), 32'd1);
      send(HB, 4, acc);
      chk("b2b_accept_b", 32'(acc), 32'd1);
      cyc = 0; fpos = 0;
      for (int i = 0; i < 40; i++) begin
         if (dv_m) begin
            cyc++;
            if (df_m && cyc > 1) fpos = cyc;
         end else if (cyc > 0) begin
            break;
         end
         tick();
      end
      chk("b2b_valid_cycles", 32'(cyc), 32'd14);
      chk("b2b_second_first_pos", 32'(fpos), 32'd8);
      wait_drain(20);

      // Backpressure fills the FIFO; sixth header held off
      dout_rdy = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
         send(tbl[k], 2, acc);
         chk("fill_accept", 32'(acc), 32'd1);
      end
      send(tbl[5], 3, acc);
      chk("full_holdoff", 32'(acc), 32'd0);
      chk("full_hdr_cnt", 32'(cnt_m), 32'd4);
      chk("full_hdr_rdy", 32'(rdy_m), 32'd0);
      chk("full_word0", 32'(dout_m), 32'h0011);
      dout_rdy = 1'b1;
      wait_drain(80);

      // Random backpressure against the scoreboard
      rnd_mode = 1'b1;
      for (int k = 0; k < 8; k++) begin
         h = {$urandom, $urandom, $urandom, $urandom};
         send(h, 60, acc);
         chk("rnd_accept", 32'(acc), 32'd1);
      end
      wait_drain(600);
      rnd_mode = 1'b0;
      dout_rdy = 1'b1;
      tick();

      // Reset in the middle of word 3 with another header queued
      send(HA, 4, acc);
      send(HB, 4, acc);
      tick(); tick(); tick();
      chk("pre_reset_word3", 32'(dout_m), 32'h0A09);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_dout_valid", 32'(dv_m), 32'd0);
      chk("midrst_dout", 32'(dout_m), 32'd0);
      chk("midrst_first", 32'(df_m), 32'd0);
      chk("midrst_last", 32'(dl_m), 32'd0);
      chk("midrst_hdr_cnt", 32'(cnt_m), 32'd0);
      chk("midrst_hdr_rdy", 32'(rdy_m), 32'd0);
      exp_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      chk("rerst_rdy_low", 32'(rdy_m), 32'd0);
      tick();
      send(HC, 4, acc);
      chk("post_rst_accept", 32'(acc), 32'd1);
      tick();
      chk("post_rst_word0", 32'(dout_m), 32'h005A);
      chk("post_rst_first", 32'(df_m), 32'd1);
      wait_drain(40);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mdom_wvb_hdr_packer.md
MDOM_WVB_HDR_PACKER -- requirements
Module: mdom_wvb_hdr_packer

Interface
REQ-001 Parameter HDR_W, default 104, SHALL set the header bundle width in bits.
REQ-002 Parameter WORD_W, default 16, SHALL set the output word width in bits.
REQ-003 Parameter DEPTH, default 4, SHALL set the header FIFO depth (power of 2, >=2).
REQ-004 Parameter MSW_FIRST, default 1: 1 = most significant word first, 0 = least significant word first.
REQ-005 Derived N_WORDS SHALL equal ceil(HDR_W/WORD_W); 7 at defaults.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 hdr_in  in  HDR_W  header bundle to enqueue.
REQ-009 hdr_valid  in  1  hdr_in valid.
REQ-010 hdr_rdy  out  1  space available in the header FIFO.
REQ-011 dout  out  WORD_W  serialized header word.
REQ-012 dout_valid  out  1  dout valid.
REQ-013 dout_rdy  in  1  downstream accepts dout.
REQ-014 dout_first  out  1  dout is the first word of a header.
REQ-015 dout_last  out  1  dout is the last word of a header.
REQ-016 hdr_cnt  out  clog2(DEPTH)+1  headers held in the FIFO, excluding the one being sent.

Function
REQ-017 A header SHALL be accepted on a rising edge where hdr_valid=1 and hdr_rdy=1; hdr_in is zero-extended to N_WORDS*WORD_W bits and written to the FIFO.
REQ-018 hdr_rdy SHALL equal (hdr_cnt < DEPTH), with no combinational path from dout_rdy; a same-cycle pop does not raise it.
REQ-019 hdr_valid while hdr_rdy=0 SHALL be ignored, leaving FIFO contents unchanged.
REQ-020 A push and pop on the same edge SHALL leave hdr_cnt unchanged; the FIFO pointers wrap modulo DEPTH.
REQ-021 The output FSM SHALL have two states: IDLE and SEND.
REQ-022 In IDLE with hdr_cnt>0, the next edge SHALL pop the FIFO head into the shift register, clear the word index to 0 and enter SEND.
REQ-023 In SEND, dout_valid SHALL be 1, and a word SHALL transfer on an edge where dout_valid=1 and dout_rdy=1.
REQ-024 Word k (k=0..N_WORDS-1) SHALL be bits [(N_WORDS-1-k)*WORD_W +: WORD_W] when MSW_FIRST=1, and bits [k*WORD_W +: WORD_W] when MSW_FIRST=0.
REQ-025 dout_first SHALL be 1 only while k=0; dout_last SHALL be 1 only while k=N_WORDS-1; both SHALL be qualified by dout_valid.
REQ-026 dout, dout_first and dout_last SHALL hold stable while dout_valid=1 and dout_rdy=0.
REQ-027 On transfer of the last word with hdr_cnt>0, the FSM SHALL pop the next header on the same edge and stay in SEND, with no idle cycle between headers.
REQ-028 On transfer of the last word with hdr_cnt=0, the FSM SHALL return to IDLE.
REQ-029 Latency: a header accepted on edge n into an empty block SHALL present word 0 with dout_valid=1 after edge n+1.
REQ-030 N_WORDS=1 SHALL assert dout_first and dout_last together.

Reset
REQ-031 While rst_n=0, the block SHALL be in IDLE with hdr_cnt=0, hdr_rdy=0, dout_valid=0, dout_first=0, dout_last=0 and dout=0.
REQ-032 FIFO pointers, word index and the shift register SHALL reset to 0.
REQ-033 Reset asserted mid-header SHALL discard the partial header and all queued headers.
REQ-034 The first acceptance SHALL occur no earlier than the first edge after rst_n deasserts; hdr_rdy rises on that edge.

Verification
REQ-035 Single header with defaults, padded value 0x0006_0005_0004_0003_0002_0001_0000 and dout_rdy=1 -> 7 consecutive words 0x0006 down to 0x0000; first on 0x0006, last on 0x0000; word 0 valid 2 edges after acceptance.
REQ-036 Same header with MSW_FIRST=0 -> words 0x0000 up to 0x0006; first on 0x0000, last on 0x0006.
REQ-037 dout_rdy=0 while offering 6 headers -> 1 popped into the shift register, 4 accepted into the FIFO, hdr_cnt=4, hdr_rdy=0, and the 6th header held off; releasing dout_rdy drains all 5 headers in order with exact data.
REQ-038 Two queued headers with dout_rdy=1 -> 14 consecutive valid cycles and dout_first on cycle 8, with no bubble.
REQ-039 dout_rdy randomly toggled -> every stalled word is held stable, and no word is dropped or duplicated versus a reference model.
REQ-040 rst_n pulled low during word 3 -> outputs are at their reset values immediately; after release, a new header is emitted from word 0 correctly.
